operand_fwd_reg: RTL and testbench
==================================

# operand_fwd_reg

Parametrised operand-forwarding selector with an integrated pipeline register, used at the ID/EX boundary of the pipelined RISC-V core. It picks one operand from the register-file read value or from `NUM_SRC` prioritised forwarding sources (EX/MEM, MEM/WB, …), registers it with stall and flush control, and refreshes a stalled operand when a late forwarding source matches. It replaces the fixed 2:1 operand muxes and adds a saturating forward-hit counter for performance monitoring.

## Interface
- `WIDTH`, 32, data width
- `ADDR_W`, 5, register-address width
- `NUM_SRC`, 3, number of forwarding sources; index 0 is highest priority (youngest producer)
- `CNT_W`, 16, forward-hit counter width
- `SEL_W`, `$clog2(NUM_SRC+1)` (derived, not overridable), width of `out_sel`

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operand request valid
- `in_addr`  in  ADDR_W  source register address
- `in_data`  in  WIDTH  register-file read data for `in_addr`
- `fwd_valid`  in  NUM_SRC  per-source write-enable (producer writes a register)
- `fwd_addr`  in  NUM_SRC*ADDR_W  per-source destination address; source i at `[i*ADDR_W +: ADDR_W]`
- `fwd_data`  in  NUM_SRC*WIDTH  per-source result; source i at `[i*WIDTH +: WIDTH]`
- `stall`  in  1  hold the pipeline register
- `flush`  in  1  invalidate the pipeline register
- `out_valid`  out  1  registered operand valid
- `out_data`  out  WIDTH  registered operand
- `out_sel`  out  SEL_W  chosen source: 0 = register file, i+1 = forwarding source i
- `fwd_count`  out  CNT_W  saturating count of forwarded loads

## Operation
- Match for source i: `fwd_valid[i]`, `fwd_addr[i] == addr`, and `addr != 0`.
- Selection is combinational on `in_addr`. The lowest matching index wins. With no match, the operand is `in_data` and the selector is 0.
- Address 0 always gives data 0 and selector 0, whatever `in_data` or any forward is.
- Internal held-address register `hold_addr` (ADDR_W) stores the address of the registered operand.
- Load (`flush=0`, `stall=0`):
  - `out_valid <= in_valid`
  - `out_data <= selected data`
  - `out_sel <= selector`
  - `hold_addr <= in_addr`
  - Data and selector are loaded even when `in_valid=0`.
- Stall (`flush=0`, `stall=1`):
  - `out_valid`, `hold_addr` and `fwd_count` hold.
  - Refresh: if `out_valid=1` and some source matches `hold_addr`, `out_data` and `out_sel` are replaced by the highest-priority matching source (`out_sel <= i+1`). Otherwise they hold.
  - No refresh from `in_data`.
- Flush (`flush=1`): `out_valid <= 0`, `out_data <= 0`, `out_sel <= 0`, `hold_addr <= 0`. Flush has priority over stall.
- Counter: `fwd_count` increments by 1 on a load with `in_valid=1` and selector ≠ 0. It saturates at 2^CNT_W−1 and never wraps. Refreshes and flushes do not count. It is cleared only by reset.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_sel=0`, `fwd_count=0`, `hold_addr=0`. Outputs change immediately on `reset` assertion, independent of `clk`.
- Latency: 1 cycle from inputs to registered outputs. No combinational path from inputs to outputs.
- Simultaneous events:
  - `flush`+`stall`: flush wins.
  - Multiple matching sources: lowest index wins.
  - `fwd_count` at max with a forwarded load: stays at max.
- Reset asserted mid-stall discards the held operand. The first edge after reset release loads normally.
- Back-to-back loads: every non-stalled cycle accepts a new operand. There is no handshake beyond `stall`.

## Test plan
- Reset, then load `in_addr=5`, `in_data=0x11`, no forwards → `out_valid=1`, `out_data=0x11`, `out_sel=0`, `fwd_count=0`.
- `in_addr=7`, sources 0 and 2 both valid to addr 7 with data 0xAAAA/0xCCCC → `out_data=0xAAAA`, `out_sel=1`, `fwd_count=1`. Then source 0 invalid → `out_data=0xCCCC`, `out_sel=3`, `fwd_count=2`.
- `in_addr=0`, `in_data=0xDEAD`, source 1 valid to addr 0 with 0xBEEF → `out_data=0`, `out_sel=0`, count unchanged.
- Load addr 9 from the register file (0x1), then `stall=1`. Next cycle source 2 writes addr 9 with 0x99 → `out_data=0x99`, `out_sel=3`, `out_valid=1`, count unchanged. Release stall → next operand loads.
- `stall=1` and `flush=1` together → `out_valid=0`, `out_data=0`, `out_sel=0`. A subsequent matching forward during stall does not refresh.
- `CNT_W=4`: 17 forwarded loads → `fwd_count=15`. Assert `reset` between clock edges → all outputs 0 immediately.

Source files
------------

// File: rtl/operand_fwd_reg_if.sv
// Operand request, forwarding-source and registered-operand bundle for operand_fwd_reg.
// The master drives requests and forwards; the slave returns the registered operand.
interface operand_fwd_reg_if #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned NUM_SRC = 3,
   parameter int unsigned CNT_W   = 16
);
   localparam int unsigned SEL_W = $clog2(NUM_SRC + 1);

   logic                        in_valid;
   logic [ADDR_W-1:0]           in_addr;
   logic [WIDTH-1:0]            in_data;
   logic [NUM_SRC-1:0]          fwd_valid;
   logic [NUM_SRC*ADDR_W-1:0]   fwd_addr;
   logic [NUM_SRC*WIDTH-1:0]    fwd_data;
   logic                        stall;
   logic                        flush;
   logic                        out_valid;
   logic [WIDTH-1:0]            out_data;
   logic [SEL_W-1:0]            out_sel;
   logic [CNT_W-1:0]            fwd_count;

   modport master (
      output in_valid, in_addr, in_data, fwd_valid, fwd_addr, fwd_data, stall, flush,
      input  out_valid, out_data, out_sel, fwd_count
   );

   modport slave (
      input  in_valid, in_addr, in_data, fwd_valid, fwd_addr, fwd_data, stall, flush,
      output out_valid, out_data, out_sel, fwd_count
   );
endinterface

// File: rtl/operand_fwd_reg.sv
// ID/EX operand selector: picks the register-file value or the youngest matching forward,
// registers it with stall/flush control, refreshes stalled operands, counts forwarded loads.
module operand_fwd_reg #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned NUM_SRC = 3,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   operand_fwd_reg_if.slave  bus
);
   localparam int unsigned SEL_W = $clog2(NUM_SRC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_data_q,  out_data_d;
   logic [SEL_W-1:0]  out_sel_q,   out_sel_d;
   logic [CNT_W-1:0]  fwd_count_q, fwd_count_d;
   logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;

   logic [WIDTH-1:0]  sel_data;
   logic [SEL_W-1:0]  sel_idx;
   logic              ref_hit;
   logic [WIDTH-1:0]  ref_data;
   logic [SEL_W-1:0]  ref_idx;

   // Request selection; scanning high-to-low leaves the lowest matching index in place.
   always_comb begin
      sel_data = bus.in_data;
      sel_idx  = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (bus.fwd_valid[i] && (bus.fwd_addr[i*ADDR_W +: ADDR_W] == bus.in_addr)) begin
            sel_data = bus.fwd_data[i*WIDTH +: WIDTH];
            sel_idx  = SEL_W'(i + 1);
         end
      end
      if (bus.in_addr == '0) begin
         sel_data = '0;
         sel_idx  = '0;
      end
   end

   // Late-forward match against the held operand's address; x0 never matches.
   always_comb begin
      ref_hit  = 1'b0;
      ref_data = '0;
      ref_idx  = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (bus.fwd_valid[i] && (bus.fwd_addr[i*ADDR_W +: ADDR_W] == hold_addr_q)) begin
            ref_hit  = 1'b1;
            ref_data = bus.fwd_data[i*WIDTH +: WIDTH];
            ref_idx  = SEL_W'(i + 1);
         end
      end
      if (hold_addr_q == '0) begin
         ref_hit = 1'b0;
      end
   end

   // Next-state: flush beats stall; stall only refreshes from forwards.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      fwd_count_d = fwd_count_q;
      hold_addr_d = hold_addr_q;
      if (bus.flush) begin
         out_valid_d = 1'b0;
         out_data_d  = '0;
         out_sel_d   = '0;
         hold_addr_d = '0;
      end else if (!bus.stall) begin
         out_valid_d = bus.in_valid;
         out_data_d  = sel_data;
         out_sel_d   = sel_idx;
         hold_addr_d = bus.in_addr;
         if (bus.in_valid && (sel_idx != '0) && (fwd_count_q != CNT_MAX)) begin
            fwd_count_d = fwd_count_q + CNT_W'(1);
         end
      end else if (out_valid_q && ref_hit) begin
         out_data_d = ref_data;
         out_sel_d  = ref_idx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         fwd_count_q <= '0;
         hold_addr_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         fwd_count_q <= fwd_count_d;
         hold_addr_q <= hold_addr_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;
   assign bus.fwd_count = fwd_count_q;
endmodule

// File: tb/tb_operand_fwd_reg.sv
// Directed bench for operand_fwd_reg: default instance plus a 4-bit-counter instance.
module tb_operand_fwd_reg;
   logic clk;
   logic reset;
   int   n_chk;
   int   n_pass;

   operand_fwd_reg_if #(.WIDTH(32), .ADDR_W(5), .NUM_SRC(3), .CNT_W(16)) ia ();
   operand_fwd_reg_if #(.WIDTH(32), .ADDR_W(5), .NUM_SRC(3), .CNT_W(4))  ib ();

   operand_fwd_reg #(.WIDTH(32), .ADDR_W(5), .NUM_SRC(3), .CNT_W(16)) u_dut_a (
      .clk(clk), .reset(reset), .bus(ia));
   operand_fwd_reg #(.WIDTH(32), .ADDR_W(5), .NUM_SRC(3), .CNT_W(4)) u_dut_b (
      .clk(clk), .reset(reset), .bus(ib));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fwd(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
      ia.fwd_valid[i]        = v;
      ia.fwd_addr[i*5 +: 5]  = a;
      ia.fwd_data[i*32 +: 32] = d;
   endtask

   task automatic clr_fwd();
      ia.fwd_valid = '0;
      ia.fwd_addr  = '0;
      ia.fwd_data  = '0;
   endtask

   task automatic chk_a(input string tag, input logic v, input logic [31:0] d,
                        input logic [1:0] s, input logic [15:0] c);
      chk({tag, ".valid"}, 32'(ia.out_valid), 32'(v));
      chk({tag, ".data"},  ia.out_data, d);
      chk({tag, ".sel"},   32'(ia.out_sel), 32'(s));
      chk({tag, ".count"}, 32'(ia.fwd_count), 32'(c));
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      reset = 1'b1;
      ia.in_valid = 1'b0; ia.in_addr = '0; ia.in_data = '0;
      ia.stall = 1'b0; ia.flush = 1'b0;
      clr_fwd();
      ib.in_valid = 1'b0; ib.in_addr = '0; ib.in_data = '0;
      ib.fwd_valid = '0; ib.fwd_addr = '0; ib.fwd_data = '0;
      ib.stall = 1'b0; ib.flush = 1'b0;
      tick();
      chk_a("reset", 1'b0, 32'h0, 2'd0, 16'd0);
      reset = 1'b0;

      // Register-file operand, no forwards
      ia.in_valid = 1'b1; ia.in_addr = 5'd5; ia.in_data = 32'h11;
      tick();
      chk_a("rf_load", 1'b1, 32'h11, 2'd0, 16'd0);

      // Two matches: source 0 wins, then source 2 after source 0 drops
      ia.in_addr = 5'd7; ia.in_data = 32'h7777;
      set_fwd(0, 1'b1, 5'd7, 32'hAAAA);
      set_fwd(2, 1'b1, 5'd7, 32'hCCCC);
      tick();
      chk_a("prio0", 1'b1, 32'hAAAA, 2'd1, 16'd1);
      set_fwd(0, 1'b0, 5'd7, 32'hAAAA);
      tick();
      chk_a("prio2", 1'b1, 32'hCCCC, 2'd3, 16'd2);

      // x0 ignores both in_data and forwards
      clr_fwd();
      ia.in_addr = 5'd0; ia.in_data = 32'hDEAD;
      set_fwd(1, 1'b1, 5'd0, 32'hBEEF);
      tick();
      chk_a("x0", 1'b1, 32'h0, 2'd0, 16'd2);

      // Stall, then a late forward refreshes the held operand
      clr_fwd();
      ia.in_addr = 5'd9; ia.in_data = 32'h1;
      tick();
      chk_a("ld9", 1'b1, 32'h1, 2'd0, 16'd2);
      ia.stall = 1'b1; ia.in_addr = 5'd3; ia.in_data = 32'h55;
      tick();
      chk_a("stall_hold", 1'b1, 32'h1, 2'd0, 16'd2);
      set_fwd(2, 1'b1, 5'd9, 32'h99);
      tick();
      chk_a("refresh", 1'b1, 32'h99, 2'd3, 16'd2);
      clr_fwd();
      ia.stall = 1'b0; ia.in_addr = 5'd4; ia.in_data = 32'h44;
      tick();
      chk_a("unstall", 1'b1, 32'h44, 2'd0, 16'd2);

      // Flush beats stall; no refresh afterwards
      ia.stall = 1'b1; ia.flush = 1'b1;
      tick();
      chk_a("flush", 1'b0, 32'h0, 2'd0, 16'd2);
      ia.flush = 1'b0;
      set_fwd(0, 1'b1, 5'd4, 32'h77);
      tick();
      chk_a("no_refresh", 1'b0, 32'h0, 2'd0, 16'd2);

      // Load with in_valid=0 still captures data/selector but does not count
      ia.stall = 1'b0; ia.in_valid = 1'b0;
      tick();
      chk_a("inv_load", 1'b0, 32'h77, 2'd1, 16'd2);

      // 4-bit counter saturates at 15
      ib.in_valid = 1'b1; ib.in_addr = 5'd1; ib.in_data = 32'h3;
      ib.fwd_valid = 3'b001; ib.fwd_addr = 15'd1; ib.fwd_data = 96'h5;
      for (int i = 0; i < 14; i++) tick();
      chk("cnt14", 32'(ib.fwd_count), 32'd14);
      tick();
      chk("cnt15", 32'(ib.fwd_count), 32'd15);
      tick();
      tick();
      chk("cnt_sat", 32'(ib.fwd_count), 32'd15);
      chk("b_data", ib.out_data, 32'h5);

      // Asynchronous reset mid-stall, between edges
      ia.stall = 1'b1;
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk_a("async_rst", 1'b0, 32'h0, 2'd0, 16'd0);
      chk("b_rst_cnt", 32'(ib.fwd_count), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      ia.stall = 1'b0; ia.in_valid = 1'b1; ia.in_addr = 5'd5; ia.in_data = 32'h22;
      clr_fwd();
      tick();
      chk_a("post_rst", 1'b1, 32'h22, 2'd0, 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
